// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// Tracks FIFO occupancy itself so a write is only issued when a slot is free.
module fifo_wr_arbiter #(
  parameter int unsigned BITS       = 12,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WORD_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned ID_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*BITS-1:0]   req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    fifo_write,
  output logic [BITS-1:0]         fifo_data_in,
  input  logic                    fifo_read,
  input  logic                    fifo_ready,
  input  logic                    fifo_overflow,
  input  logic                    clr_err,
  output logic [ADDR_WIDTH:0]     level,
  output logic                    full,
  output logic                    err
);

  localparam int unsigned CapInt = WORD_DEPTH - 1;
  localparam logic [ADDR_WIDTH:0] Cap = CapInt[ADDR_WIDTH:0];

  typedef enum logic [1:0] {StIdle, StGrant, StFull, StError} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
  logic                  fifo_write_q, fifo_write_d;
  logic [BITS-1:0]       fifo_data_q, fifo_data_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;

  logic                  found;
  logic [ID_W-1:0]       win;
  int unsigned           j;
  logic                  grant;
  logic                  rd_take;

  // First active requester scanning upward from rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j[ID_W-1:0]]) begin
        found = 1'b1;
        win   = j[ID_W-1:0];
      end
    end
  end

  // An overflow seen at this edge already blocks the grant.
  assign grant   = found && (state_q != StError) && !fifo_overflow && (level_q < Cap);
  assign rd_take = fifo_read && fifo_ready && (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (grant && !rd_take) begin
      level_d = level_q + 1'b1;
    end else if (!grant && rd_take) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (fifo_overflow || (state_q == StError && !clr_err)) begin
      state_d = StError;
    end else if (level_d == Cap) begin
      state_d = StFull;
    end else if (grant) begin
      state_d = StGrant;
    end
  end

  always_comb begin
    gnt_d        = '0;
    gnt_id_d     = gnt_id_q;
    fifo_write_d = grant;
    fifo_data_d  = fifo_data_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      gnt_d[win]  = 1'b1;
      gnt_id_d    = win;
      fifo_data_d = req_data[32'(win) * BITS +: BITS];
      rr_ptr_d    = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
    full_d = (level_d == Cap);
    err_d  = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      level_q      <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      level_q      <= level_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      full_q       <= full_d;
      err_q        <= err_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_id       = gnt_id_q;
  assign fifo_write   = fifo_write_q;
  assign fifo_data_in = fifo_data_q;
  assign level        = level_q;
  assign full         = full_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter with a queue-level reference model
// and a small FIFO model standing in for the SRAM FIFO.
module tb_fifo_wr_arbiter;

  localparam int BITS  = 12;
  localparam int N_REQ = 4;
  localparam int CAP   = 7;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*BITS-1:0] req_data = '0;
  logic [N_REQ-1:0]      gnt;
  logic [1:0]            gnt_id;
  logic                  fifo_write;
  logic [BITS-1:0]       fifo_data_in;
  logic                  fifo_read = 1'b0;
  logic                  fifo_ready = 1'b0;
  logic                  fifo_overflow = 1'b0;
  logic                  clr_err = 1'b0;
  logic [3:0]            level;
  logic                  full;
  logic                  err;

  fifo_wr_arbiter #(
    .BITS(BITS), .N_REQ(N_REQ), .WORD_DEPTH(8), .ADDR_WIDTH(3), .ID_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .gnt_id(gnt_id),
    .fifo_write(fifo_write), .fifo_data_in(fifo_data_in), .fifo_read(fifo_read),
    .fifo_ready(fifo_ready), .fifo_overflow(fifo_overflow), .clr_err(clr_err),
    .level(level), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    int               id;
    logic             wr;
    int               lvl;
    logic             full;
    logic             err;
  } st_t;

  typedef struct {
    int              id;
    logic [BITS-1:0] data;
  } wr_t;

  st_t             st_q[$];
  wr_t             wr_q[$];
  logic [BITS-1:0] fifo_mem[$];

  int m_level, m_rr, m_last_id;
  bit m_err;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ*BITS-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[N_REQ*BITS-1:0];
  endfunction

  // Reference: what the arbiter must show after the coming edge, from the current inputs.
  task automatic model_step();
    int  win;
    bit  rd_eff;
    st_t s;
    wr_t w;
    win = -1;
    if (!m_err && !fifo_overflow && m_level < CAP && req != '0) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % N_REQ;
        if (win < 0 && req[idx]) win = idx;
      end
    end
    rd_eff = fifo_read && fifo_ready && (m_level > 0);
    m_level = m_level + ((win >= 0) ? 1 : 0) - (rd_eff ? 1 : 0);
    if (fifo_overflow) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
    s.gnt = '0;
    if (win >= 0) begin
      s.gnt[win] = 1'b1;
      m_last_id  = win;
      m_rr       = (win + 1) % N_REQ;
      w.id       = win;
      w.data     = req_data[win*BITS +: BITS];
      wr_q.push_back(w);
    end
    s.id   = m_last_id;
    s.wr   = (win >= 0);
    s.lvl  = m_level;
    s.full = (m_level == CAP);
    s.err  = m_err;
    st_q.push_back(s);
  endtask

  task automatic drive(input logic [N_REQ-1:0] r, input logic [N_REQ*BITS-1:0] d,
                       input logic rd, input logic ovf, input logic clr);
    @(negedge clk);
    req           = r;
    req_data      = d;
    fifo_read     = rd;
    fifo_overflow = ovf;
    clr_err       = clr;
    fifo_ready    = (fifo_mem.size() > 0);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; fifo_read = 1'b0; fifo_overflow = 1'b0; clr_err = 1'b0; fifo_ready = 1'b0;
    rst_n = 1'b0;
    m_level = 0; m_rr = 0; m_last_id = 0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // FIFO stand-in: stores the word on the edge after fifo_write is seen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem.delete();
    end else begin
      if (fifo_read && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
      if (fifo_write) fifo_mem.push_back(fifo_data_in);
    end
  end

  // Monitor: compares every modelled cycle, and pops a write entry whenever one appears.
  always @(posedge clk) begin : monitor
    st_t s;
    wr_t w;
    #1;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("gnt", 32'(gnt), 32'(s.gnt));
      chk("gnt_id", 32'(gnt_id), s.id);
      chk("fifo_write", 32'(fifo_write), 32'(s.wr));
      chk("level", 32'(level), s.lvl);
      chk("full", 32'(full), 32'(s.full));
      chk("err", 32'(err), 32'(s.err));
      if (fifo_write) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_id", 32'(gnt_id), w.id);
          chk("wr_data", 32'(fifo_data_in), 32'(w.data));
        end
      end
    end
  end

  initial begin
    logic [N_REQ*BITS-1:0] d;
    m_level = 0; m_rr = 0; m_last_id = 0; m_err = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_fifo_write", 32'(fifo_write), 0);
    chk("rst_fifo_data_in", 32'(fifo_data_in), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (5) drive('0, rnd_data(), 1'b0, 1'b0, 1'b0);

    // Single requester with known data.
    d = rnd_data();
    d[1*BITS +: BITS] = 12'hABC;
    drive(4'b0010, d, 1'b0, 1'b0, 1'b0);
    repeat (2) drive('0, rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("fifo_data_out", (fifo_mem.size() > 0) ? 32'(fifo_mem[0]) : 32'hFFFF, 32'hABC);
    repeat (3) drive('0, rnd_data(), 1'b1, 1'b0, 1'b0);

    // Round robin from rr_ptr=0, then one more to see the pointer wrap to 0.
    do_reset();
    repeat (4) drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);
    drive('0, rnd_data(), 1'b0, 1'b0, 1'b0);
    drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);

    // Fill to capacity, then free one slot with a single read.
    do_reset();
    repeat (9) drive(4'b0001, rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("fifo_count_full", fifo_mem.size(), CAP);
    drive(4'b0001, rnd_data(), 1'b1, 1'b0, 1'b0);
    repeat (3) drive(4'b0001, rnd_data(), 1'b0, 1'b0, 1'b0);

    // Grant and read on the same edge at level 3.
    do_reset();
    repeat (3) drive(4'b0001, rnd_data(), 1'b0, 1'b0, 1'b0);
    drive(4'b0001, rnd_data(), 1'b1, 1'b0, 1'b0);
    repeat (2) drive('0, rnd_data(), 1'b0, 1'b0, 1'b0);

    // Overflow, clear blocked by concurrent overflow, then a real clear.
    do_reset();
    drive(4'b1111, rnd_data(), 1'b0, 1'b1, 1'b0);
    repeat (3) drive(4'b1111, rnd_data(), 1'b1, 1'b0, 1'b0);
    drive(4'b1111, rnd_data(), 1'b0, 1'b1, 1'b1);
    drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);
    drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b1);
    repeat (3) drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    do_reset();
    repeat (400) begin
      drive(4'($urandom), rnd_data(), ($urandom % 3) == 0, ($urandom % 60) == 0,
            ($urandom % 8) == 0);
    end
    repeat (2) drive('0, rnd_data(), 1'b0, 1'b0, 1'b1);

    // Asynchronous reset asserted while a grant is on the outputs.
    do_reset();
    drive(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_status", st_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_fifo_write", 32'(fifo_write), 0);
    chk("async_level", 32'(level), 0);
    chk("async_gnt_id", 32'(gnt_id), 0);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO-SRAM write port between N_REQ producers.
- Keeps its own occupancy count, so no write is issued when the FIFO cannot accept it. The FIFO is therefore never driven into overflow.
- Sits between the producer blocks and the FIFO write side. The consumer's read strobe is monitored so occupancy is tracked exactly.

Parameters:
- BITS, 12, data word width; matches FIFO BITS.
- N_REQ, 4, number of requesters (2..8).
- WORD_DEPTH, 8, FIFO depth; usable capacity CAP = WORD_DEPTH-1 (one slot is always kept empty).
- ADDR_WIDTH, 3, FIFO pointer width; level width is ADDR_WIDTH+1.
- ID_W, 2, requester index width, ceil(log2(N_REQ)).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester write request, held until granted.
- req_data  in  N_REQ*BITS  packed data; slice i = bits [i*BITS +: BITS].
- gnt  out  N_REQ  one-hot, one-cycle grant pulse.
- gnt_id  out  ID_W  index of the last granted requester.
- fifo_write  out  1  drives FIFO write.
- fifo_data_in  out  BITS  drives FIFO data_in.
- fifo_read  in  1  consumer read strobe (same net that drives FIFO read).
- fifo_ready  in  1  FIFO has-data flag.
- fifo_overflow  in  1  FIFO overflow flag.
- clr_err  in  1  clears sticky error.
- level  out  ADDR_WIDTH+1  reserved/occupied entry count.
- full  out  1  level == CAP.
- err  out  1  sticky: overflow was seen.

Behaviour:
- Reset (async, rst_n low): gnt=0, gnt_id=0, fifo_write=0, fifo_data_in=0, level=0, full=0, err=0, rr_ptr=0, state=IDLE. Reset takes effect immediately, even mid-grant. The FIFO shares rst_n, so level=0 is coherent with it.
- All outputs are registered.
- FSM states:
  - IDLE: no grant in flight.
  - GRANT: a grant was issued at the last edge.
  - FULL: level==CAP.
  - ERROR: err set.
- Grant condition at an edge: state != ERROR, level < CAP, and |req. The comparison uses the pre-edge level, so a same-cycle read does not free a slot until the next cycle.
- Winner selection: the first requester with req set, scanning from rr_ptr upward, mod N_REQ.
- On a grant to requester i, at that edge:
  - gnt[i]=1, gnt_id=i, fifo_write=1, fifo_data_in=req_data slice i;
  - rr_ptr = (i+1) mod N_REQ;
  - state=GRANT, or FULL if the new level==CAP.
- With no grant at an edge: gnt=0, fifo_write=0, fifo_data_in holds its value. state=FULL if level==CAP, else IDLE.
- Handshake rules:
  - A requester sees gnt[i] in the cycle after its data was captured.
  - It may change req_data or drop req from that cycle on.
  - If req stays high, it is re-arbitrated; it is granted again only after the other active requesters (round robin).
- Throughput: one write per cycle while slots remain.
- Latency: request to fifo_write assertion is 1 cycle; the FIFO stores the word on the following edge.
- Level update per edge:
  - +1 on a grant (reservation);
  - -1 when fifo_read && fifo_ready;
  - both in the same edge: level unchanged.
  - level never exceeds CAP and never goes below 0.
- full = (level == CAP).
- Overflow handling:
  - fifo_overflow sampled high sets err=1 and state=ERROR; no further grants are issued.
  - level keeps tracking reads.
  - clr_err high with fifo_overflow low clears err; the next state is IDLE or FULL per level.
  - If clr_err and fifo_overflow are high in the same cycle, err stays 1.
- Arithmetic: rr_ptr wraps modulo N_REQ; for non-power-of-2 N_REQ, wrap explicitly at N_REQ-1 -> 0. level is unsigned, ADDR_WIDTH+1 bits.
- Invariant: at most one bit of gnt is set, and fifo_write == |gnt.

Test Plan:
- Reset: after reset deassert with req=0 -> gnt=0, fifo_write=0, level=0, full=0, err=0 for 5 cycles.
- Single requester: req=4'b0010 with data 0xABC held for 1 cycle -> next cycle gnt=4'b0010, gnt_id=1, fifo_write=1, fifo_data_in=0xABC; level=1; FIFO data_out=0xABC two cycles after the request.
- Round robin: req=4'b1111 held for 4 cycles, no reads -> grants 0,1,2,3 in order on consecutive cycles; level reaches 4; rr_ptr returns to 0.
- Fill: req=4'b0001 held, no reads -> exactly 7 grants, then gnt=0 with full=1 and level=7; FIFO overflow stays 0.
- Full plus read: at level=7, a single fifo_read pulse -> level=6 at that edge; the held request is granted one cycle later and level returns to 7.
- Simultaneous grant and read at level=3 -> level stays 3.
- Error: force fifo_overflow=1 for 1 cycle -> err=1 and no grants while req=4'b1111; clr_err pulse -> err=0 and grants resume on the next cycle.
